// File: rtl/serial_adder_ctrl.sv
// Bit-serial add controller: drives one full-adder cell over WIDTH cycles,
// LSB first, to produce (op_a + op_b + cin) mod 2^WIDTH and the carry out.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   s_sh_q, s_sh_d;
    logic               c_q, c_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               cell_sum;
    logic               cell_carry;
    logic               last_bit;
    logic [WIDTH-1:0]   s_next;

    // Shared 1-bit full-adder cell fed from the shift-register LSBs
    assign cell_sum   = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
    assign cell_carry = (a_sh_q[0] & b_sh_q[0]) | (b_sh_q[0] & c_q) | (a_sh_q[0] & c_q);
    assign last_bit   = (cnt_q == CNT_W'(WIDTH - 1));
    assign s_next     = (s_sh_q >> 1) | (WIDTH'(cell_sum) << (WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_bit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered status outputs
    always_comb begin
        a_sh_d = a_sh_q;
        b_sh_d = b_sh_q;
        s_sh_d = s_sh_q;
        c_d    = c_q;
        cnt_d  = cnt_q;
        sum_d  = sum_q;
        cout_d = cout_q;
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d = op_a;
                    b_sh_d = op_b;
                    s_sh_d = '0;
                    c_d    = cin;
                    cnt_d  = '0;
                end
            end
            S_RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                s_sh_d = s_next;
                c_d    = cell_carry;
                cnt_d  = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    sum_d  = s_next;
                    cout_d = cell_carry;
                end
            end
            default: ;
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: WIDTH=8 and WIDTH=1 instances
// checked every cycle against a transaction-level countdown model.
module tb_serial_adder_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start8, cin8;
    logic [7:0] a8, b8;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;
    logic       start1, cin1;
    logic [0:0] a1, b1;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 0;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op_a(a8), .op_b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op_a(a1), .op_b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: an accepted request keeps the block busy for WIDTH+1 cycles, the
    // last of which is the done cycle, when the arithmetic result appears.
    int         m8_rem = 0;
    logic [7:0] m8_sum = '0, m8_pend = '0;
    logic       m8_cout = 1'b0, m8_pcout = 1'b0;
    int         m1_rem = 0;
    logic [0:0] m1_sum = '0, m1_pend = '0;
    logic       m1_cout = 1'b0, m1_pcout = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m8_rem <= 0; m8_sum <= '0; m8_cout <= 1'b0;
            m1_rem <= 0; m1_sum <= '0; m1_cout <= 1'b0;
        end else begin
            if (m8_rem == 0) begin
                if (start8) begin
                    {m8_pcout, m8_pend} <= 9'(a8) + 9'(b8) + 9'(cin8);
                    m8_rem <= 9;
                end
            end else begin
                m8_rem <= m8_rem - 1;
                if (m8_rem == 2) begin
                    m8_sum  <= m8_pend;
                    m8_cout <= m8_pcout;
                end
            end
            if (m1_rem == 0) begin
                if (start1) begin
                    {m1_pcout, m1_pend} <= 2'(a1) + 2'(b1) + 2'(cin1);
                    m1_rem <= 2;
                end
            end else begin
                m1_rem <= m1_rem - 1;
                if (m1_rem == 2) begin
                    m1_sum  <= m1_pend;
                    m1_cout <= m1_pcout;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("w8_busy", 32'(busy8), 32'(m8_rem != 0));
            check("w8_done", 32'(done8), 32'(m8_rem == 1));
            check("w8_sum",  32'(sum8),  32'(m8_sum));
            check("w8_cout", 32'(cout8), 32'(m8_cout));
            check("w1_busy", 32'(busy1), 32'(m1_rem != 0));
            check("w1_done", 32'(done1), 32'(m1_rem == 1));
            check("w1_sum",  32'(sum1),  32'(m1_sum));
            check("w1_cout", 32'(cout1), 32'(m1_cout));
        end
    end

    // One request on the 8-bit instance with literal expectations on result and timing
    task automatic add8(input string nm, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic [7:0] es, input logic ec);
        int edges = 0;
        int busy_cnt = 0;
        bit seen = 0;
        @(posedge clk); #2;
        start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
        @(posedge clk); #2;
        start8 = 1'b0; a8 = ~a; b8 = ~b; cin8 = ~c;
        while (!seen && edges < 30) begin
            if (busy8) busy_cnt++;
            if (done8) seen = 1;
            else begin
                @(posedge clk); #2;
                edges++;
            end
        end
        check({nm, "_latency"}, 32'(edges), 32'd8);
        check({nm, "_busy_cycles"}, 32'(busy_cnt), 32'd9);
        check({nm, "_sum"}, 32'(sum8), 32'(es));
        check({nm, "_cout"}, 32'(cout8), 32'(ec));
        @(posedge clk); #2;
        check({nm, "_idle_after"}, 32'({busy8, done8}), 32'd0);
    endtask

    initial begin
        int ndone;
        int last_done;
        int done_idx;
        logic [7:0] sum_tt;
        logic [7:0] cout_tt;

        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        @(posedge clk); #2;
        cmp_en = 1'b1;
        @(posedge clk); #2;
        check("reset_w8", 32'({busy8, done8, cout8, sum8}), 32'd0);
        check("reset_w1", 32'({busy1, done1, cout1, sum1}), 32'd0);
        rst_n = 1'b1;

        // Basic adds and carry boundaries
        add8("t1", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        add8("t2a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        add8("t2b", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

        // Starts during RUN are ignored
        @(posedge clk); #2;
        start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1;
        @(posedge clk); #2;
        start8 = 1'b0;
        ndone = 0;
        for (int i = 1; i <= 20; i++) begin
            if (i == 3 || i == 6) begin
                start8 = 1'b1; a8 = 8'hEE; b8 = 8'h77; cin8 = 1'b1;
            end else begin
                start8 = 1'b0;
            end
            @(posedge clk); #2;
            if (done8) ndone++;
        end
        check("t3_done_pulses", 32'(ndone), 32'd1);
        check("t3_sum", 32'({cout8, sum8}), 32'h047);

        // Reset after four bits of an add
        @(posedge clk); #2;
        start8 = 1'b1; a8 = 8'h77; b8 = 8'h99; cin8 = 1'b1;
        @(posedge clk); #2;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_reset_w8", 32'({busy8, done8, cout8, sum8}), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        add8("t4_fresh", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);

        // Back-to-back with start held high
        ndone = 0; last_done = -1; done_idx = 0;
        for (int i = 0; i < 45; i++) begin
            start8 = 1'b1;
            a8 = 8'(i * 37); b8 = 8'(i * 11 + 3); cin8 = i[0];
            @(posedge clk); #2;
            if (done8) begin
                if (done_idx == 0) check("t5_first_sum", 32'({cout8, sum8}), 32'h003);
                if (done_idx == 1) check("t5_second_sum", 32'({cout8, sum8}), 32'h0E3);
                if (last_done >= 0) check("t5_spacing", 32'(i - last_done), 32'd10);
                last_done = i;
                done_idx++;
            end
        end
        check("t5_done_count", 32'(done_idx), 32'd4);
        start8 = 1'b0;
        repeat (12) @(posedge clk);
        #2;

        // WIDTH=1 full-adder truth table, index = {a, b, cin}
        sum_tt  = 8'b1001_0110;
        cout_tt = 8'b1110_1000;
        for (int k = 0; k < 8; k++) begin
            start1 = 1'b1; a1 = 1'(k >> 2); b1 = 1'(k >> 1); cin1 = 1'(k);
            @(posedge clk); #2;
            start1 = 1'b0;
            ndone = 0;
            for (int j = 0; j < 99; j++) begin
                @(posedge clk); #2;
                if (done1) ndone++;
            end
            check("t6_done_pulses", 32'(ndone), 32'd1);
            check("t6_sum", 32'(sum1), 32'(sum_tt[k]));
            check("t6_cout", 32'(cout1), 32'(cout_tt[k]));
        end

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
